// File: rtl/cnn_pkg.sv
// Shared CNN datapath widths and the argmax classifier state encoding.
package cnn_pkg;

  localparam int DATA_W      = 32;
  localparam int NUM_CLASSES = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RESULT = 2'd2
  } state_t;

endpackage

// File: rtl/argmax_classifier.sv
// Streams NUM_CLASSES signed scores and reports the first maximum as index, one-hot and value.
// Result registers one cycle after the last handshake; done pulses as it becomes valid.
module argmax_classifier #(
  parameter int DATA_W      = cnn_pkg::DATA_W,
  parameter int NUM_CLASSES = cnn_pkg::NUM_CLASSES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     score_valid,
  input  logic signed [DATA_W-1:0] score_in,
  output logic                     score_ready,
  output logic [NUM_CLASSES-1:0]   classes,
  output logic [3:0]               class_idx,
  output logic [DATA_W-1:0]        max_score,
  output logic                     done,
  output logic                     busy
);
  import cnn_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

  state_t                     state, state_nxt;
  logic [3:0]                 cnt;
  logic [3:0]                 run_idx;
  logic signed [DATA_W-1:0]   run_max;
  logic                       hs;
  logic                       last_hs;

  assign score_ready = (state == LOAD);
  assign busy        = (state != IDLE);
  assign hs          = score_valid & score_ready;
  assign last_hs     = hs && (cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // start restarts from any state, so an in-flight inference is simply dropped
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (start) state_nxt = LOAD;
               else if (last_hs) state_nxt = RESULT;
      RESULT:  state_nxt = start ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      run_idx   <= '0;
      run_max   <= '0;
      classes   <= '0;
      class_idx <= '0;
      max_score <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        cnt       <= '0;
        run_idx   <= '0;
        run_max   <= '0;
        classes   <= '0;
        class_idx <= '0;
        max_score <= '0;
      end else if (hs) begin
        cnt <= cnt + 4'd1;
        // strict greater-than keeps the lower index on ties
        if (cnt == 4'd0 || score_in > run_max) begin
          run_max <= score_in;
          run_idx <= cnt;
        end
      end else if (state == RESULT) begin
        class_idx <= run_idx;
        max_score <= run_max;
        classes   <= NUM_CLASSES'(1) << run_idx;
        done      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier with a result scoreboard and immediate assertions.
module tb_argmax_classifier;
  localparam int DW = 32;
  localparam int NC = 10;

  typedef logic signed [DW-1:0] vec_t [NC];
  typedef struct {
    logic [3:0]    idx;
    logic [DW-1:0] mx;
    logic [NC-1:0] cls;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst, start, score_valid;
  logic signed [DW-1:0] score_in;
  logic                 score_ready;
  logic [NC-1:0]        classes;
  logic [3:0]           class_idx;
  logic [DW-1:0]        max_score;
  logic                 done, busy;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt++;

  argmax_classifier #(.DATA_W(DW), .NUM_CLASSES(NC)) dut (
    .clk(clk), .rst(rst), .start(start), .score_valid(score_valid),
    .score_in(score_in), .score_ready(score_ready), .classes(classes),
    .class_idx(class_idx), .max_score(max_score), .done(done), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: first strictly-greater score wins
  function automatic exp_t model(input vec_t s);
    exp_t e;
    logic signed [DW-1:0] m;
    e.idx = 4'd0;
    m = s[0];
    for (int i = 1; i < NC; i++)
      if (s[i] > m) begin
        m     = s[i];
        e.idx = 4'(i);
      end
    e.mx  = m;
    e.cls = NC'(1) << e.idx;
    return e;
  endfunction

  task automatic pulse_start(input logic with_score);
    start       = 1'b1;
    score_valid = with_score;
    score_in    = 32'sd1000;
    @(posedge clk); #1;
    start       = 1'b0;
    score_valid = 1'b0;
  endtask

  task automatic send(input vec_t s, input int n, input bit bub, output int hs0, output int nbub);
    int  i = 0;
    int  guard = 0;
    logic v, hs;
    nbub = 0;
    hs0  = -1;
    while (i < n && guard < 300) begin
      v           = bub ? 1'($urandom_range(0, 1)) : 1'b1;
      score_valid = v;
      score_in    = v ? s[i] : 32'sh5A5A5A5A;
      hs          = v && score_ready;
      if (hs && i == 0) hs0 = cyc;
      @(posedge clk); #1;
      if (hs) i++;
      else if (i > 0) nbub++;
      guard++;
    end
    score_valid = 1'b0;
    if (i < n) chk("send_timeout", 64'(i), 64'(n));
  endtask

  task automatic wait_done(input string tag, input int hs0, input int nbub);
    exp_t e;
    bit   seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_idx"}, 64'(class_idx), 64'(e.idx));
      chk({tag, "_classes"}, 64'(classes), 64'(e.cls));
      chk({tag, "_max"}, 64'(max_score), 64'(e.mx));
      chk({tag, "_latency"}, 64'(cyc - hs0), 64'(11 + nbub));
      chk({tag, "_busy_low"}, 64'(busy), 64'd0);
      @(posedge clk); #1;
      chk({tag, "_done_1cyc"}, 64'(done), 64'd0);
      chk({tag, "_hold_idx"}, 64'(class_idx), 64'(e.idx));
    end
  endtask

  initial begin
    vec_t d_base, d_neg, d_ext, d_part, d_fresh;
    int   hs0, nb, dc;
    d_base  = '{3, -1, 7, 2, 7, 0, -5, 6, 1, 4};
    d_neg   = '{-9, -4, -8, -7, -6, -5, -10, -11, -12, -4};
    d_part  = '{100, 200, 300, 400, 500, 0, 0, 0, 0, 0};
    d_fresh = '{1, 2, 3, 4, 5, 6, -7, 8, 9, 0};
    for (int i = 0; i < NC; i++) d_ext[i] = (i == 9) ? 32'sh7FFFFFFF : 32'sh80000000;

    rst = 1'b1; start = 1'b0; score_valid = 1'b0; score_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_classes", 64'(classes), 64'd0);
    chk("rst_idx", 64'(class_idx), 64'd0);
    chk("rst_max", 64'(max_score), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(score_ready), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // valid in IDLE is ignored
    score_valid = 1'b1; score_in = 32'sd55;
    repeat (2) @(posedge clk);
    #1;
    score_valid = 1'b0;
    chk("idle_ignore_busy", 64'(busy), 64'd0);

    pulse_start(1'b1);
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_ready", 64'(score_ready), 64'd1);
    sb.push_back(model(d_base));
    send(d_base, NC, 1'b0, hs0, nb);
    wait_done("basic", hs0, nb);

    pulse_start(1'b0);
    chk("clear_classes", 64'(classes), 64'd0);
    chk("clear_max", 64'(max_score), 64'd0);
    sb.push_back(model(d_neg));
    send(d_neg, NC, 1'b0, hs0, nb);
    wait_done("neg_tie", hs0, nb);

    pulse_start(1'b0);
    sb.push_back(model(d_ext));
    send(d_ext, NC, 1'b0, hs0, nb);
    wait_done("extreme", hs0, nb);

    pulse_start(1'b0);
    sb.push_back(model(d_base));
    send(d_base, NC, 1'b1, hs0, nb);
    wait_done("bubbles", hs0, nb);

    dc = done_cnt;
    pulse_start(1'b0);
    send(d_part, 5, 1'b0, hs0, nb);
    pulse_start(1'b1);
    chk("abort_ready", 64'(score_ready), 64'd1);
    sb.push_back(model(d_fresh));
    send(d_fresh, NC, 1'b0, hs0, nb);
    wait_done("abort", hs0, nb);
    chk("abort_one_done", 64'(done_cnt - dc), 64'd1);

    dc = done_cnt;
    pulse_start(1'b0);
    send(d_base, 4, 1'b0, hs0, nb);
    rst = 1'b1; start = 1'b1; score_valid = 1'b1; score_in = 32'sd9;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("midrst_classes", 64'(classes), 64'd0);
    chk("midrst_idx", 64'(class_idx), 64'd0);
    chk("midrst_max", 64'(max_score), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'(score_ready), 64'd0);
    repeat (15) @(posedge clk);
    #1;
    score_valid = 1'b0;
    chk("midrst_ready_hold", 64'(score_ready), 64'd0);
    chk("midrst_no_done", 64'(done_cnt - dc), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
